// File: rtl/cu_pkg.sv
// cu_pkg: shared memory-stage types (FSM state enum, load/store funct3 codes)
package cu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks byte/half/word of rdata at lane lo and sign/zero-extends per funct3 into data
module mem_load_align
    import cu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{lo, 3'b000} +: 8];
    assign h = lo[1] ? rdata[31:16] : rdata[15:0];
    assign data = funct3 == F3_B  ? {{24{b[7]}}, b}  :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_BU ? {24'd0, b}       :
                  funct3 == F3_HU ? {16'd0, h}       : rdata;
endmodule

// File: rtl/cu_mem_stage.sv
// cu_mem_stage: EX->WB memory stage; takes EX results (ex_*, rs2_data, mem_*, rd_addr, MEM_accept), drives a single-outstanding dmem_* bus with timeout, emits one wb_* record plus misalign_flag/bus_err_flag per op
module cu_mem_stage
    import cu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        soc_clk,
    input  logic        MEM_reset,
    input  logic [31:0] ex_result_data,
    input  logic        ex_result_ready,
    input  logic        ex_error_flag,
    input  logic [31:0] rs2_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [4:0]  rd_addr,
    output logic        MEM_accept,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misalign_flag,
    output logic        bus_err_flag
);
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);
    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  lo_q, lo_d;
    logic        dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        misalign_q, misalign_d, bus_err_q, bus_err_d;
    logic        mem_op, is_h, is_w, bad, pass, done;
    logic [31:0] ld_data;
    mem_load_align u_align (
        .rdata  (dmem_rdata),
        .lo     (lo_q),
        .funct3 (f3_q),
        .data   (ld_data)
    );
    assign mem_op = mem_read | mem_write;
    assign is_h   = mem_funct3[1:0] == 2'b01;
    assign is_w   = mem_funct3[1:0] == 2'b10;
    // a simultaneous load+store is reported through the misalign path
    assign bad    = (mem_read & mem_write) | (is_h & ex_result_data[0]) | (is_w & (|ex_result_data[1:0]));
    assign pass   = !mem_op && !ex_error_flag;
    assign done   = dmem_ack || cnt_d == TMO;
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        rd_d         = rd_q;
        lo_d         = lo_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        misalign_d   = misalign_q;
        bus_err_d    = bus_err_q;
        if (state_q == IDLE && ex_result_ready) begin
            f3_d = mem_funct3;
            rd_d = rd_addr;
            lo_d = ex_result_data[1:0];
            if (!mem_op || ex_error_flag || bad) begin
                state_d    = RESP;
                wb_valid_d = 1'b1;
                wb_we_d    = pass && rd_addr != 5'd0;
                wb_rd_d    = rd_addr;
                wb_data_d  = pass ? ex_result_data : 32'd0;
                misalign_d = mem_op && bad;
                bus_err_d  = 1'b0;
            end else begin
                state_d      = REQ;
                cnt_d        = 8'd0;
                dmem_req_d   = 1'b1;
                dmem_we_d    = mem_write;
                dmem_addr_d  = {ex_result_data[31:2], 2'b00};
                dmem_be_d    = mem_funct3[1:0] == 2'b00 ? 4'b0001 << ex_result_data[1:0] :
                               is_h ? 4'b0011 << ex_result_data[1:0] : 4'b1111;
                dmem_wdata_d = mem_funct3[1:0] == 2'b00 ? {4{rs2_data[7:0]}} :
                               is_h ? {2{rs2_data[15:0]}} : rs2_data;
            end
        end else if (state_q == REQ) begin
            cnt_d = cnt_q == TMO ? cnt_q : cnt_q + 8'd1;
            if (done) begin
                state_d    = RESP;
                dmem_req_d = 1'b0;
                dmem_we_d  = 1'b0;
                wb_valid_d = 1'b1;
                wb_we_d    = dmem_ack && !dmem_we_q && rd_q != 5'd0;
                wb_rd_d    = rd_q;
                wb_data_d  = dmem_ack && !dmem_we_q ? ld_data : 32'd0;
                misalign_d = 1'b0;
                bus_err_d  = !dmem_ack;
            end
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge soc_clk) begin
        if (MEM_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            lo_q         <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            rd_q         <= rd_d;
            lo_q         <= lo_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
            bus_err_q    <= bus_err_d;
        end
    end
    assign MEM_accept    = state_q == IDLE;
    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_be       = dmem_be_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_we         = wb_we_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign misalign_flag = misalign_q;
    assign bus_err_flag  = bus_err_q;
endmodule

// File: tb/tb_cu_mem_stage.sv
// tb_cu_mem_stage: directed and randomized checks of cu_mem_stage against a behavioural memory-stage model
module tb_cu_mem_stage;
    localparam int TMO = 4;
    logic        soc_clk, MEM_reset;
    logic [31:0] ex_result_data, rs2_data, dmem_rdata;
    logic        ex_result_ready, ex_error_flag, mem_read, mem_write, dmem_ack;
    logic [2:0]  mem_funct3;
    logic [4:0]  rd_addr;
    logic        MEM_accept, dmem_req, dmem_we, wb_valid, wb_we, misalign_flag, bus_err_flag;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;
    int checks = 0;
    int failures = 0;
    typedef struct packed {
        logic        got, unstable, extra, acc_wb, acc_after, we, wbwe, mis, berr;
        int          lat, reqs;
        logic [31:0] addr, wd, data, rdata;
        logic [3:0]  be;
        logic [4:0]  rd;
    } obs_t;
    typedef struct packed {
        logic        we, mis, berr;
        int          lat, reqs;
        logic [31:0] addr, wd, data;
        logic [3:0]  be;
    } exp_t;
    cu_mem_stage #(.TIMEOUT_CYC(TMO)) dut (
        .soc_clk(soc_clk), .MEM_reset(MEM_reset),
        .ex_result_data(ex_result_data), .ex_result_ready(ex_result_ready), .ex_error_flag(ex_error_flag),
        .rs2_data(rs2_data), .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .rd_addr(rd_addr), .MEM_accept(MEM_accept), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_flag(misalign_flag), .bus_err_flag(bus_err_flag)
    );
    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;
    function automatic exp_t model(input logic [31:0] a, r2, input logic ri, wi, err, input logic [2:0] f3,
                                   input logic [4:0] rd, input int k, input logic [31:0] rdata);
        exp_t e;
        int sz, off;
        logic [63:0] v, mask;
        e = '0;
        e.lat = 1;
        sz = 1 << (f3 % 4);
        off = a % 4;
        if (!(ri || wi)) begin
            e.data = err ? 32'd0 : a;
            e.we = !err && rd != 0;
        end else if (err || (ri && wi) || off % sz != 0) begin
            e.mis = (ri && wi) || off % sz != 0;
        end else begin
            e.addr = a - 32'(off);
            mask = (64'd1 << (8 * sz)) - 1;
            e.be = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = 8'(r2 >> (8 * (i % sz)));
            if (k >= TMO) begin
                e.reqs = TMO;
                e.lat = TMO + 1;
                e.berr = 1'b1;
            end else begin
                e.reqs = k + 1;
                e.lat = k + 2;
                if (ri) begin
                    v = (64'(rdata) >> (8 * off)) & mask;
                    if (f3 < 4 && v[8*sz-1]) v = v | ~mask;
                    e.data = v[31:0];
                    e.we = rd != 0;
                end
            end
        end
        return e;
    endfunction
    task automatic run_op(input logic [31:0] a, r2, input logic ri, wi, err, input logic [2:0] f3,
                          input logic [4:0] rd, input int k, input bit fixrd, input logic [31:0] rdv,
                          output obs_t o);
        o = '0;
        dmem_ack = 1'b0;
        ex_result_data = a; rs2_data = r2; mem_read = ri; mem_write = wi;
        ex_error_flag = err; mem_funct3 = f3; rd_addr = rd; ex_result_ready = 1'b1;
        @(posedge soc_clk);
        #1 ex_result_ready = 1'b0;
        for (int c = 1; c <= 40 && !o.got; c++) begin
            @(negedge soc_clk);
            if (dmem_req) begin
                if (o.reqs == 0) begin
                    o.addr = dmem_addr; o.be = dmem_be; o.wd = dmem_wdata; o.we = dmem_we;
                end else if (dmem_addr !== o.addr || dmem_be !== o.be || dmem_wdata !== o.wd || dmem_we !== o.we) begin
                    o.unstable = 1'b1;
                end
                dmem_rdata = fixrd ? rdv : $urandom;
                dmem_ack = o.reqs == k;
                if (dmem_ack) o.rdata = dmem_rdata;
                o.reqs++;
            end else begin
                dmem_ack = 1'b0;
            end
            if (wb_valid) begin
                o.got = 1'b1; o.lat = c; o.wbwe = wb_we; o.rd = wb_rd; o.data = wb_data;
                o.mis = misalign_flag; o.berr = bus_err_flag; o.acc_wb = MEM_accept;
            end
        end
        dmem_ack = 1'b0;
        if (o.got) begin
            @(negedge soc_clk);
            o.extra = wb_valid;
            o.acc_after = MEM_accept;
        end
    endtask
    task automatic test_reset;
        MEM_reset = 1'b1;
        repeat (2) @(posedge soc_clk);
        @(negedge soc_clk);
        checks++;
        if ({MEM_accept, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 70'd0}) begin
            failures++;
            $display("FAIL reset_bus got acc=%b req=%b we=%b addr=%h be=%b wd=%h", MEM_accept, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
        end
        checks++;
        if ({wb_valid, wb_we, wb_rd, wb_data, misalign_flag, bus_err_flag} !== 41'd0) begin
            failures++;
            $display("FAIL reset_wb got v=%b we=%b rd=%0d data=%h mis=%b berr=%b required all 0", wb_valid, wb_we, wb_rd, wb_data, misalign_flag, bus_err_flag);
        end
        MEM_reset = 1'b0;
    endtask
    task automatic test_pass_through;
        obs_t o;
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5, 0, 1'b0, 32'd0, o);
        checks++;
        if ({o.got, o.lat, o.reqs} !== {1'b1, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL pass_timing got got=%b lat=%0d reqs=%0d required 1/1/0", o.got, o.lat, o.reqs);
        end
        checks++;
        if ({o.wbwe, o.rd, o.data, o.mis, o.berr} !== {1'b1, 5'd5, 32'h1234_5678, 2'b00}) begin
            failures++;
            $display("FAIL pass_wb got we=%b rd=%0d data=%h mis=%b berr=%b required 1/5/12345678/0/0", o.wbwe, o.rd, o.data, o.mis, o.berr);
        end
        checks++;
        if ({o.acc_wb, o.extra, o.acc_after} !== 3'b001) begin
            failures++;
            $display("FAIL pass_pulse got acc_wb=%b extra=%b acc_after=%b required 0/0/1", o.acc_wb, o.extra, o.acc_after);
        end
    endtask
    task automatic test_load_sign;
        obs_t o;
        run_op(32'h0000_0103, 32'd0, 1'b1, 1'b0, 1'b0, 3'd0, 5'd7, 0, 1'b1, 32'h80FF_0000, o);
        checks++;
        if ({o.addr, o.we, o.lat, o.data, o.wbwe} !== {32'h100, 1'b0, 32'd2, 32'hFFFF_FF80, 1'b1}) begin
            failures++;
            $display("FAIL lb got addr=%h we=%b lat=%0d data=%h wbwe=%b required 100/0/2/ffffff80/1", o.addr, o.we, o.lat, o.data, o.wbwe);
        end
        run_op(32'h0000_0103, 32'd0, 1'b1, 1'b0, 1'b0, 3'd4, 5'd7, 0, 1'b1, 32'h80FF_0000, o);
        checks++;
        if ({o.addr, o.lat, o.data, o.wbwe} !== {32'h100, 32'd2, 32'h0000_0080, 1'b1}) begin
            failures++;
            $display("FAIL lbu got addr=%h lat=%0d data=%h wbwe=%b required 100/2/00000080/1", o.addr, o.lat, o.data, o.wbwe);
        end
    endtask
    task automatic test_store_half;
        obs_t o;
        run_op(32'h0000_0202, 32'hAAAA_BEEF, 1'b0, 1'b1, 1'b0, 3'd1, 5'd3, 0, 1'b0, 32'd0, o);
        checks++;
        if ({o.addr, o.be, o.wd, o.we} !== {32'h200, 4'b1100, 32'hBEEF_BEEF, 1'b1}) begin
            failures++;
            $display("FAIL sh_bus got addr=%h be=%b wd=%h we=%b required 200/1100/beefbeef/1", o.addr, o.be, o.wd, o.we);
        end
        checks++;
        if ({o.got, o.wbwe, o.mis, o.berr} !== 4'b1000) begin
            failures++;
            $display("FAIL sh_wb got got=%b we=%b mis=%b berr=%b required 1/0/0/0", o.got, o.wbwe, o.mis, o.berr);
        end
    endtask
    task automatic test_misalign;
        obs_t o;
        run_op(32'h0000_0101, 32'd0, 1'b1, 1'b0, 1'b0, 3'd2, 5'd9, 0, 1'b0, 32'd0, o);
        checks++;
        if ({o.got, o.mis, o.wbwe, o.reqs, o.data} !== {3'b110, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL lw_misalign got got=%b mis=%b we=%b reqs=%0d data=%h required 1/1/0/0/0", o.got, o.mis, o.wbwe, o.reqs, o.data);
        end
    endtask
    task automatic test_timeout;
        obs_t o;
        run_op(32'h0000_0400, 32'd0, 1'b1, 1'b0, 1'b0, 3'd2, 5'd4, 99, 1'b0, 32'd0, o);
        checks++;
        if ({o.got, o.reqs, o.lat, o.berr, o.wbwe, o.unstable} !== {1'b1, 32'd4, 32'd5, 3'b100}) begin
            failures++;
            $display("FAIL timeout got got=%b reqs=%0d lat=%0d berr=%b we=%b unstable=%b required 1/4/5/1/0/0", o.got, o.reqs, o.lat, o.berr, o.wbwe, o.unstable);
        end
    endtask
    task automatic test_back_to_back;
        int pulses, accepts;
        pulses = 0;
        accepts = 0;
        ex_result_data = 32'hCAFE_0001; mem_read = 1'b0; mem_write = 1'b0; ex_error_flag = 1'b0;
        rd_addr = 5'd1; ex_result_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge soc_clk);
            pulses += int'(wb_valid);
            accepts += int'(MEM_accept);
        end
        ex_result_ready = 1'b0;
        @(negedge soc_clk);
        @(negedge soc_clk);
        checks++;
        if (pulses != 3 || accepts != 3) begin
            failures++;
            $display("FAIL back_to_back got pulses=%0d accepts=%0d required 3/3", pulses, accepts);
        end
    endtask
    task automatic test_random;
        obs_t o;
        exp_t e;
        logic [31:0] a, r2;
        logic ri, wi, err;
        logic [2:0] f3;
        logic [4:0] rd;
        int kind, k;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(7);
            ri = kind inside {[2:4], 7};
            wi = kind inside {[5:7]};
            err = $urandom_range(7) == 0;
            a = $urandom; r2 = $urandom; rd = 5'($urandom);
            f3 = wi ? 3'($urandom_range(2)) : ri ? 3'(5'b10111 >> 0) : 3'($urandom);
            if (ri && !wi) begin
                k = $urandom_range(4);
                f3 = k == 0 ? 3'd0 : k == 1 ? 3'd1 : k == 2 ? 3'd2 : k == 3 ? 3'd4 : 3'd5;
            end
            k = $urandom_range(5);
            run_op(a, r2, ri, wi, err, f3, rd, k, 1'b0, 32'd0, o);
            e = model(a, r2, ri, wi, err, f3, rd, k, o.rdata);
            checks++;
            if (!o.got || o.lat != e.lat || o.reqs != e.reqs || o.extra || !o.acc_after) begin
                failures++;
                $display("FAIL rand%0d timing got got=%b lat=%0d reqs=%0d extra=%b required lat=%0d reqs=%0d", i, o.got, o.lat, o.reqs, o.extra, e.lat, e.reqs);
            end
            checks++;
            if ({o.wbwe, o.rd, o.data, o.mis, o.berr} !== {e.we, rd, e.data, e.mis, e.berr}) begin
                failures++;
                $display("FAIL rand%0d wb got we=%b rd=%0d data=%h mis=%b berr=%b required %b/%0d/%h/%b/%b", i, o.wbwe, o.rd, o.data, o.mis, o.berr, e.we, rd, e.data, e.mis, e.berr);
            end
            if (e.reqs > 0) begin
                checks++;
                if (o.addr !== e.addr || o.we !== wi || o.unstable || (wi && (o.be !== e.be || o.wd !== e.wd))) begin
                    failures++;
                    $display("FAIL rand%0d bus got addr=%h we=%b be=%b wd=%h unstable=%b required %h/%b/%b/%h", i, o.addr, o.we, o.be, o.wd, o.unstable, e.addr, wi, e.be, e.wd);
                end
            end
        end
    endtask
    task automatic test_reset_mid_req;
        int seen;
        seen = 0;
        ex_result_data = 32'h0000_0800; mem_read = 1'b1; mem_write = 1'b0; ex_error_flag = 1'b0;
        mem_funct3 = 3'd2; rd_addr = 5'd2; dmem_ack = 1'b0; ex_result_ready = 1'b1;
        @(posedge soc_clk);
        #1 ex_result_ready = 1'b0;
        @(negedge soc_clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++;
            $display("FAIL rst_req_setup got req=%b required 1", dmem_req);
        end
        MEM_reset = 1'b1;
        @(negedge soc_clk);
        checks++;
        if ({dmem_req, MEM_accept} !== 2'b01) begin
            failures++;
            $display("FAIL rst_mid_req got req=%b acc=%b required 0/1", dmem_req, MEM_accept);
        end
        MEM_reset = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(negedge soc_clk);
        dmem_ack = 1'b0;
        seen += int'(wb_valid);
        for (int c = 0; c < 4; c++) begin
            @(negedge soc_clk);
            seen += int'(wb_valid) + int'(dmem_req);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_late_ack got activity=%0d required 0", seen);
        end
    endtask
    initial begin
        MEM_reset = 1'b1; ex_result_ready = 1'b0; ex_error_flag = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        ex_result_data = '0; rs2_data = '0; mem_funct3 = '0; rd_addr = '0; dmem_rdata = '0; dmem_ack = 1'b0;
        test_reset;
        test_pass_through;
        test_load_sign;
        test_store_half;
        test_misalign;
        test_timeout;
        test_back_to_back;
        test_random;
        test_reset_mid_req;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
